// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/divide unit owning the HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) at one bit per cycle and
// serves MFHI/MFLO/MTHI/MTLO in a single cycle when idle.
module ex_muldiv #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CNTW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [5:0]        functin,
    input  logic [DWIDTH-1:0] rsdata,
    input  logic [DWIDTH-1:0] rtdata,
    output logic              stall,
    output logic              busy,
    output logic [DWIDTH-1:0] result,
    output logic [DWIDTH-1:0] hiout,
    output logic [DWIDTH-1:0] loout,
    output logic              done
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [2*DWIDTH-1:0]   acc_q, acc_d;
    logic [DWIDTH-1:0]     opb_q, opb_d;
    logic [DWIDTH-1:0]     hi_q, hi_d;
    logic [DWIDTH-1:0]     lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  div0_q, div0_d;
    logic                  neg_q, neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  done_q, done_d;

    logic                  op_mul, op_div, op_signed, op_hilo;
    logic                  op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic [DWIDTH-1:0]     rs_mag, rt_mag;
    logic [DWIDTH:0]       mul_sum;
    logic [DWIDTH:0]       div_shift;
    logic [DWIDTH:0]       div_diff;
    logic [2*DWIDTH-1:0]   prod_fix;
    logic [DWIDTH-1:0]     quot_fix, rem_fix;

    // Decode the funct field and form signed-operand magnitudes.
    always_comb begin
        op_mul    = valid && (functin == F_MULT || functin == F_MULTU);
        op_div    = valid && (functin == F_DIV  || functin == F_DIVU);
        op_mthi   = valid && (functin == F_MTHI);
        op_mtlo   = valid && (functin == F_MTLO);
        op_mfhi   = valid && (functin == F_MFHI);
        op_mflo   = valid && (functin == F_MFLO);
        op_hilo   = op_mul || op_div || op_mthi || op_mtlo || op_mfhi || op_mflo;
        op_signed = (functin == F_MULT) || (functin == F_DIV);
        rs_mag    = (op_signed && rsdata[DWIDTH-1]) ? (~rsdata + 1'b1) : rsdata;
        rt_mag    = (op_signed && rtdata[DWIDTH-1]) ? (~rtdata + 1'b1) : rtdata;
    end

    // One iteration of shift-add / restoring divide plus the sign fix-up used in FINISH.
    always_comb begin
        // Multiplier sits in the low half and is consumed LSB first while the
        // partial product grows into the high half.
        mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Remainder in the high half, dividend/quotient in the low half.
        div_shift = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = neg_q ? (~acc_q[DWIDTH-1:0] + 1'b1) : acc_q[DWIDTH-1:0];
        rem_fix   = rem_neg_q ? (~acc_q[2*DWIDTH-1:DWIDTH] + 1'b1) : acc_q[2*DWIDTH-1:DWIDTH];
    end

    // Next-state and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_mul || op_div) begin
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_d     = op_signed && (rsdata[DWIDTH-1] ^ rtdata[DWIDTH-1]);
                    rem_neg_d = op_signed && rsdata[DWIDTH-1];
                    div0_d    = 1'b0;
                    if (op_mul) begin
                        acc_d   = {{DWIDTH{1'b0}}, rt_mag};
                        opb_d   = rs_mag;
                        state_d = ST_MUL;
                    end else if (rtdata == '0) begin
                        // Divide-by-zero result is preloaded raw; FINISH skips the sign fix.
                        acc_d   = {rsdata, {DWIDTH{1'b1}}};
                        opb_d   = '0;
                        div0_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        acc_d   = {{DWIDTH{1'b0}}, rs_mag};
                        opb_d   = rt_mag;
                        state_d = ST_DIV;
                    end
                end else if (op_mthi) begin
                    hi_d = rsdata;
                end else if (op_mtlo) begin
                    lo_d = rsdata;
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[DWIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FINISH;
            end
            ST_DIV: begin
                if (!div_diff[DWIDTH]) begin
                    acc_d = {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (div0_q) begin
                    hi_d = acc_q[2*DWIDTH-1:DWIDTH];
                    lo_d = acc_q[DWIDTH-1:0];
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*DWIDTH-1:DWIDTH];
                    lo_d = prod_fix[DWIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working registers and HI/LO with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
        end
    end

    // Status outputs and the MFHI/MFLO read path.
    always_comb begin
        busy  = (state_q != ST_IDLE);
        stall = busy && op_hilo;
        done  = done_q;
        hiout = hi_q;
        loout = lo_q;
        if (!busy && op_mfhi) begin
            result = hi_q;
        end else if (!busy && op_mflo) begin
            result = lo_q;
        end else begin
            result = '0;
        end
    end

endmodule
